// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide sequencer beside the EX-stage ALU; stalls IF/ID/EX while in flight.
// Optional feature: define MULDIV_SIGNED_EN for two's-complement MUL/MULH/DIV/REM; otherwise all ops are unsigned.
module muldiv_sequencer #(
    parameter int unsigned XLEN      = 32,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_e,
    input  logic [1:0]      op_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            stall_e,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned   CW      = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam int unsigned   AW      = 2 * XLEN;
    localparam logic [CW-1:0] LAST    = CW'(XLEN - 1);
    localparam logic [1:0]    OP_MUL  = 2'b00;
    localparam logic [1:0]    OP_MULH = 2'b01;
    localparam logic [1:0]    OP_DIV  = 2'b10;
    localparam logic [1:0]    OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_divisor;
    logic [AW-1:0]     r_acc;
    logic [XLEN-1:0]   r_result;
    logic              r_busy;
    logic              r_done;

    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_fast;
    logic [XLEN:0]     w_add;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [AW-1:0]     w_acc_nxt;
    logic [AW-1:0]     w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result_fin;

`ifdef MULDIV_SIGNED_EN
    logic              w_neg_a;
    logic              w_neg_b;
    logic              r_neg_a;
    logic              r_neg_b;

    assign w_neg_a = src_a_e[XLEN-1];
    assign w_neg_b = src_b_e[XLEN-1];
    assign w_a_mag = w_neg_a ? (XLEN'(0) - src_a_e) : src_a_e;
    assign w_b_mag = w_neg_b ? (XLEN'(0) - src_b_e) : src_b_e;
`else
    assign w_a_mag = src_a_e;
    assign w_b_mag = src_b_e;
`endif

    // Zero short-cut; a zero divisor always takes the full iteration path.
    assign w_fast = FAST_ZERO && (op_e[1] ? ((src_a_e == '0) && (src_b_e != '0))
                                          : ((src_a_e == '0) || (src_b_e == '0)));

    // One iteration: acc = {hi, lo}; MUL shifts the multiplier out of lo, DIV shifts the dividend out of lo.
    always_comb begin
        w_add     = {1'b0, r_acc[AW-1:XLEN]} + {1'b0, (r_acc[0] ? r_divisor : '0)};
        w_shift   = {r_acc[AW-1:XLEN], r_acc[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_divisor};
        w_acc_nxt = {w_add, r_acc[XLEN-1:1]};
        if (r_op[1]) begin
            if (w_diff[XLEN])
                w_acc_nxt = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    // Final result from the last iteration's values, with sign fix-up when enabled.
    always_comb begin
        w_prod = w_acc_nxt;
        w_quo  = w_acc_nxt[XLEN-1:0];
        w_rem  = w_acc_nxt[AW-1:XLEN];
`ifdef MULDIV_SIGNED_EN
        if (r_neg_a ^ r_neg_b)
            w_prod = AW'(0) - w_acc_nxt;
        if (r_divisor == '0)
            w_quo = '1;
        else if (r_neg_a ^ r_neg_b)
            w_quo = XLEN'(0) - w_acc_nxt[XLEN-1:0];
        if (r_neg_a)
            w_rem = XLEN'(0) - w_acc_nxt[AW-1:XLEN];
`endif
        case (r_op)
            OP_MUL:  w_result_fin = w_prod[XLEN-1:0];
            OP_MULH: w_result_fin = w_prod[AW-1:XLEN];
            OP_DIV:  w_result_fin = w_quo;
            OP_REM:  w_result_fin = w_rem;
            default: w_result_fin = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state and the combinational pipeline stall.
    always_comb begin
        w_state_nxt = r_state;
        stall_e     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_e && !flush_e) begin
                    stall_e     = 1'b1;
                    w_state_nxt = w_fast ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                stall_e = !flush_e;
                if (flush_e)
                    w_state_nxt = S_IDLE;
                else if (r_count == LAST)
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!rst)
            stall_e = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_op      <= '0;
            r_divisor <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (start_e && !flush_e) begin
                        r_op      <= op_e;
                        r_count   <= '0;
                        r_divisor <= w_b_mag;
                        r_acc     <= {{XLEN{1'b0}}, w_a_mag};
`ifdef MULDIV_SIGNED_EN
                        r_neg_a   <= w_neg_a;
                        r_neg_b   <= w_neg_b;
`endif
                        if (w_fast)
                            r_result <= '0;
                    end
                end
                S_BUSY: begin
                    if (!flush_e) begin
                        r_acc   <= w_acc_nxt;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST)
                            r_result <= w_result_fin;
                    end
                end
                S_DONE:  ;
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_sequencer;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_e;
    logic [1:0]      op_e;
    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic            flush_e;
    logic            stall_e;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [XLEN-1:0] last_res;

    muldiv_sequencer #(.XLEN(XLEN), .FAST_ZERO(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_e (start_e),
        .op_e    (op_e),
        .src_a_e (src_a_e),
        .src_b_e (src_b_e),
        .flush_e (flush_e),
        .stall_e (stall_e),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the architectural M-extension results computed with wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_SIGNED_EN
        logic signed [63:0] sa, sb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
        case (op)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
            2'b10: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
        endcase
`else
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
            2'b10: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
`endif
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit fast;
        fast = op[1] ? (a == 0 && b != 0) : (a == 0 || b == 0);
        return fast ? 0 : XLEN;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Present an op before edge N; returns #1 after edge N with inputs scrambled unless held.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        @(negedge clk);
        op_e = op; src_a_e = a; src_b_e = b; start_e = 1'b1; flush_e = 1'b0;
        #1 check_eq("stall_on_start", stall_e, 1);
        @(posedge clk); #1;
        start_e = hold;
        if (!hold) begin
            op_e = 2'($urandom); src_a_e = $urandom; src_b_e = $urandom;
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int k = 0;
        bit stall_ok = 1'b1;
        while (done !== 1'b1 && k < int'(XLEN) + 8) begin
            if (stall_e !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check_eq({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check_eq({tag, "_stall_busy"}, stall_ok, 1);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_stall_in_done"}, stall_e, 0);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_result_held"}, result, exp_res);
        last_res = exp_res;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
        launch(op, a, b, 1'b0);
        wait_done(tag, ref_latency(op, a, b), exp_res);
    endtask

    initial begin
        bit saw_done;
        logic [1:0]  op;
        logic [31:0] a, b;

        rst = 1'b0; start_e = 1'b0; op_e = '0; src_a_e = '0; src_b_e = '0; flush_e = 1'b0;
        last_res = '0;
        #12;
        check_eq("reset_stall", stall_e, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_result", result, 0);
        @(negedge clk) rst = 1'b1;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42);
`ifdef MULDIV_SIGNED_EN
        run_op("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
`else
        run_op("mulh_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`endif
        run_op("div_100_7", 2'b10, 32'd100, 32'd7, 32'd14);
        run_op("rem_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        run_op("div_by0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0", 2'b11, 32'd5, 32'd0, 32'd5);
`ifdef MULDIV_SIGNED_EN
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
`else
        run_op("divu_big", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
`endif
        run_op("mul_zero_fast", 2'b00, 32'd0, 32'd123, 32'd0);
        run_op("div_0_0", 2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF);
        run_op("div_0_fast", 2'b10, 32'd0, 32'd9, 32'd0);
        run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15);

        // Flush at iteration 10: no done, result kept, stall drops at once.
        launch(2'b00, 32'd1234, 32'd5678, 1'b0);
        repeat (10) @(posedge clk);
        #1 flush_e = 1'b1;
        #1 check_eq("flush_stall_drop", stall_e, 0);
        check_eq("flush_busy_before", busy, 1);
        @(posedge clk); #1 flush_e = 1'b0;
        check_eq("flush_busy_after", busy, 0);
        check_eq("flush_result_kept", result, last_res);
        saw_done = 1'b0;
        repeat (XLEN + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_eq("flush_no_done", saw_done, 0);
        check_eq("flush_stall_idle", stall_e, 0);

        // Reset mid-BUSY, then a normal op.
        launch(2'b10, 32'd1000, 32'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_mid_stall", stall_e, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_result", result, 0);
        @(negedge clk) rst = 1'b1;
        last_res = '0;
        run_op("after_rst_div", 2'b10, 32'd1000, 32'd3, 32'd333);

        // start_e held through DONE: one op, next accepted the cycle after DONE.
        launch(2'b00, 32'd9, 32'd9, 1'b1);
        wait_done("hold_first", XLEN, 32'd81);
        check_eq("hold_idle_busy", busy, 0);
        check_eq("hold_idle_stall", stall_e, 1);
        @(posedge clk); #1;
        check_eq("hold_relaunch_busy", busy, 1);
        start_e = 1'b0;
        wait_done("hold_second", XLEN, 32'd81);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = rnd_opnd();
            b  = rnd_opnd();
            run_op("rand", op, a, b, ref_result(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
